// File: rtl/inf_pkg.sv
// Shared types and width helpers for the integrate-no-fire layer sequencer.
package inf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LD,
    ACC,
    DRN,
    OUT,
    WB,
    DONE
  } state_t;

  // Each neuron costs N_IN accumulate cycles plus RD, LD, DRN, OUT and WB.
  localparam int CYC_OVERHEAD = 5;

  function automatic int cyc_per_neuron(input int n_in);
    return n_in + CYC_OVERHEAD;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/inf_layer_seq_if.sv
// Control/strobe bundle between the layer sequencer, its controller, the neuron and the memories.
interface inf_layer_seq_if
  import inf_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int W_AW  = clog2_min1(N_IN * N_OUT),
  parameter int V_AW  = clog2_min1(N_OUT)
);

  logic            start;
  logic            first_step;
  logic [N_IN-1:0] spike_in;
  logic            busy;
  logic            done;
  logic            w_rd_en;
  logic [W_AW-1:0] w_addr;
  logic            vmem_rd_en;
  logic [V_AW-1:0] vmem_rd_addr;
  logic            vmem_wr_en;
  logic [V_AW-1:0] vmem_wr_addr;
  logic            neu_load_en;
  logic            neu_input_valid;
  logic            neu_output_en;
  logic [V_AW-1:0] cur_neuron;

  modport master (
    input  start, first_step, spike_in,
    output busy, done, w_rd_en, w_addr, vmem_rd_en, vmem_rd_addr,
           vmem_wr_en, vmem_wr_addr, neu_load_en, neu_input_valid,
           neu_output_en, cur_neuron
  );

  modport slave (
    output start, first_step, spike_in,
    input  busy, done, w_rd_en, w_addr, vmem_rd_en, vmem_rd_addr,
           vmem_wr_en, vmem_wr_addr, neu_load_en, neu_input_valid,
           neu_output_en, cur_neuron
  );

endinterface

// File: rtl/inf_layer_seq.sv
// Sequencer driving one time-multiplexed integrate-no-fire neuron across a fully connected layer:
// per output neuron it loads vmem, streams the spike-gated weight row, latches and writes back.
module inf_layer_seq
  import inf_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int W_AW  = clog2_min1(N_IN * N_OUT),
  parameter int V_AW  = clog2_min1(N_OUT)
) (
  input  logic            clk,
  input  logic            rst_n,
  inf_layer_seq_if.master bus
);

  localparam int              IW     = clog2_min1(N_IN);
  localparam logic [IW-1:0]   I_LAST = IW'(N_IN - 1);
  localparam logic [V_AW-1:0] J_LAST = V_AW'(N_OUT - 1);

  state_t          state_reg;
  state_t          state_next;
  logic [N_IN-1:0] spk_reg;
  logic            fs_reg;
  logic [IW-1:0]   i_reg;
  logic [V_AW-1:0] j_reg;
  logic [W_AW-1:0] base_reg;
  logic            valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Counters, captured inputs and the one-stage valid pipe that lines
  // neu_input_valid up with weight data returning a cycle after w_rd_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spk_reg   <= '0;
      fs_reg    <= 1'b0;
      i_reg     <= '0;
      j_reg     <= '0;
      base_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= (state_reg == ACC) && spk_reg[i_reg];
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            spk_reg  <= bus.spike_in;
            fs_reg   <= bus.first_step;
            j_reg    <= '0;
            base_reg <= '0;
          end
        end
        LD: i_reg <= '0;
        ACC: begin
          if (i_reg != I_LAST) begin
            i_reg <= i_reg + IW'(1);
          end
        end
        WB: begin
          if (j_reg != J_LAST) begin
            j_reg    <= j_reg + V_AW'(1);
            base_reg <= base_reg + W_AW'(N_IN);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next          = state_reg;
    bus.busy            = (state_reg != IDLE);
    bus.done            = 1'b0;
    bus.w_rd_en         = 1'b0;
    bus.w_addr          = '0;
    bus.vmem_rd_en      = 1'b0;
    bus.vmem_rd_addr    = j_reg;
    bus.vmem_wr_en      = 1'b0;
    bus.vmem_wr_addr    = j_reg;
    bus.neu_load_en     = 1'b0;
    bus.neu_input_valid = valid_reg;
    bus.neu_output_en   = 1'b0;
    bus.cur_neuron      = j_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RD;
        end
      end
      RD: begin
        bus.vmem_rd_en = !fs_reg;
        state_next     = LD;
      end
      LD: begin
        bus.neu_load_en = !fs_reg;
        state_next      = ACC;
      end
      ACC: begin
        bus.w_rd_en = 1'b1;
        bus.w_addr  = base_reg + W_AW'(i_reg);
        if (i_reg == I_LAST) begin
          state_next = DRN;
        end
      end
      DRN: state_next = OUT;
      OUT: begin
        bus.neu_output_en = 1'b1;
        state_next        = WB;
      end
      WB: begin
        bus.vmem_wr_en = 1'b1;
        state_next     = (j_reg == J_LAST) ? DONE : RD;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inf_layer_seq.sv
// Directed bench for inf_layer_seq with a behavioural neuron, weight ROM and membrane RAM around it.
module tb_inf_layer_seq;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int W_AW  = 3;
  localparam int V_AW  = 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  inf_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W_AW(W_AW), .V_AW(V_AW)) bus ();

  inf_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .W_AW(W_AW), .V_AW(V_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Environment: ROM, RAM and a neuron (output_en > load_en > input_valid).
  int wmem [N_IN*N_OUT];
  int vmem [N_OUT];
  int vmem_init [N_OUT];
  bit pre_en = 1'b0;
  int w_data = 0;
  int vrd_data = 0;
  int acc = 0;
  int out_vol = 0;

  always @(posedge clk) begin
    if (bus.w_rd_en) w_data <= wmem[bus.w_addr];
    if (bus.vmem_rd_en) vrd_data <= vmem[bus.vmem_rd_addr];
    if (pre_en) begin
      for (int k = 0; k < N_OUT; k++) vmem[k] <= vmem_init[k];
    end else if (bus.vmem_wr_en) begin
      vmem[bus.vmem_wr_addr] <= out_vol;
    end
    if (!rst_n) begin
      acc     <= 0;
      out_vol <= 0;
    end else if (bus.neu_output_en) begin
      out_vol <= acc;
      acc     <= 0;
    end else if (bus.neu_load_en) begin
      acc <= vrd_data;
    end else if (bus.neu_input_valid) begin
      acc <= acc + w_data;
    end
  end

  // Monitor: logs only grow; tests take marks and look at what arrived since.
  int iv_q[$];
  int waddr_q[$];
  int wr_addr_q[$];
  int wr_data_q[$];
  int ld_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int excl_bad = 0;
  int prev_waddr = -1;
  int strobes;

  always @(negedge clk) begin
    strobes = int'(bus.neu_load_en) + int'(bus.neu_input_valid) + int'(bus.neu_output_en);
    if (strobes > 1 || (bus.vmem_rd_en && bus.vmem_wr_en)) excl_bad++;
    if (bus.neu_input_valid) iv_q.push_back(prev_waddr);
    prev_waddr = bus.w_rd_en ? int'(bus.w_addr) : -1;
    if (bus.w_rd_en) waddr_q.push_back(int'(bus.w_addr));
    if (bus.neu_load_en) ld_cnt++;
    if (bus.vmem_rd_en) rd_cnt++;
    if (bus.vmem_wr_en) begin
      wr_addr_q.push_back(int'(bus.vmem_wr_addr));
      wr_data_q.push_back(out_vol);
    end
    if (bus.done) done_cnt++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic preload(input int v0, input int v1);
    vmem_init[0] = v0;
    vmem_init[1] = v1;
    pre_en = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic load_weights_seq();
    for (int k = 0; k < N_IN*N_OUT; k++) wmem[k] = k + 1;
  endtask

  task automatic start_ts(input bit fs, input logic [N_IN-1:0] spk);
    bus.start      = 1'b1;
    bus.first_step = fs;
    bus.spike_in   = spk;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.spike_in = ~spk;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done && cyc < 100);
    chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    $display("ts %s: done at cycle %0d vmem={%0d,%0d}", tag, cyc, vmem[0], vmem[1]);
    @(posedge clk);
    #1;
  endtask

  int m_iv, m_wa, m_wr, m_ld, m_rd, m_dn;

  task automatic mark();
    m_iv = iv_q.size();
    m_wa = waddr_q.size();
    m_wr = wr_addr_q.size();
    m_ld = ld_cnt;
    m_rd = rd_cnt;
    m_dn = done_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int busy_cnt;
    int done_cyc;
    logic busy20, busy21;
    int ref_v [N_OUT];
    int sum;
    bit fs;
    logic [N_IN-1:0] spk;

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.first_step = 1'b0;
    bus.spike_in   = '0;
    load_weights_seq();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", 32'({bus.busy, bus.done, bus.w_rd_en, bus.vmem_rd_en, bus.vmem_wr_en,
                            bus.neu_load_en, bus.neu_input_valid, bus.neu_output_en}), 32'd0);
    chk("rst_addrs", 32'({bus.w_addr, bus.vmem_rd_addr, bus.vmem_wr_addr, bus.cur_neuron}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: first_step, all spikes; timing and address sequence.
    preload(55, 66);
    mark();
    start_ts(1'b1, 4'b1111);
    busy_cnt = 0;
    done_cyc = 0;
    busy20   = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c <= 18 && bus.busy) busy_cnt++;
      if (bus.done) done_cyc = c;
      if (c == 20) busy20 = bus.busy;
    end
    @(posedge clk);
    #1;
    $display("ts t1: done at cycle %0d vmem={%0d,%0d}", done_cyc, vmem[0], vmem[1]);
    chk("t1_busy_cycles", busy_cnt, 18);
    chk("t1_done_cycle", done_cyc, 19);
    chk("t1_done_pulses", done_cnt - m_dn, 1);
    chk("t1_busy_after", 32'(busy20), 32'd0);
    chk("t1_waddr_count", waddr_q.size() - m_wa, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("t1_waddr%0d", k), waddr_q[m_wa + k], k);
    chk("t1_rd_count", rd_cnt - m_rd, 0);
    chk("t1_ld_count", ld_cnt - m_ld, 0);
    chk("t1_wr_count", wr_addr_q.size() - m_wr, 2);
    chk("t1_wr_addr0", wr_addr_q[m_wr], 0);
    chk("t1_wr_addr1", wr_addr_q[m_wr + 1], 1);
    chk("t1_vmem0", vmem[0], 10);
    chk("t1_vmem1", vmem[1], 26);

    // T2: load from vmem, sparse spikes 0101.
    preload(100, 50);
    mark();
    start_ts(1'b0, 4'b0101);
    wait_done("t2", cyc);
    chk("t2_cycle", cyc, 19);
    chk("t2_iv_count", iv_q.size() - m_iv, 4);
    chk("t2_iv0", iv_q[m_iv], 0);
    chk("t2_iv1", iv_q[m_iv + 1], 2);
    chk("t2_iv2", iv_q[m_iv + 2], 4);
    chk("t2_iv3", iv_q[m_iv + 3], 6);
    chk("t2_rd_count", rd_cnt - m_rd, 2);
    chk("t2_vmem0", vmem[0], 104);
    chk("t2_vmem1", vmem[1], 62);

    // T3: no spikes leaves vmem unchanged.
    preload(7, 9);
    mark();
    start_ts(1'b0, 4'b0000);
    wait_done("t3", cyc);
    chk("t3_iv_count", iv_q.size() - m_iv, 0);
    chk("t3_ld_count", ld_cnt - m_ld, 2);
    chk("t3_wr_count", wr_addr_q.size() - m_wr, 2);
    chk("t3_vmem0", vmem[0], 7);
    chk("t3_vmem1", vmem[1], 9);

    // T4: start held high, spike_in toggled mid-run.
    preload(10, 20);
    bus.start      = 1'b1;
    bus.first_step = 1'b0;
    bus.spike_in   = 4'b0011;
    @(posedge clk);
    #1;
    busy21 = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 4) bus.spike_in = 4'b1100;
      if (c == 19) begin
        chk("t4_done_c19", 32'(bus.done), 32'd1);
        chk("t4a_vmem0", vmem[0], 13);
        chk("t4a_vmem1", vmem[1], 31);
        $display("ts t4a: done at cycle %0d vmem={%0d,%0d}", c, vmem[0], vmem[1]);
      end
      if (c == 20) chk("t4_idle_gap_busy", 32'(bus.busy), 32'd0);
      if (c == 21) busy21 = bus.busy;
    end
    bus.start = 1'b0;
    chk("t4_restart_busy", 32'(busy21), 32'd1);
    mark();
    wait_done("t4b", cyc);
    chk("t4b_iv_count", iv_q.size() - m_iv, 4);
    chk("t4b_vmem0", vmem[0], 20);
    chk("t4b_vmem1", vmem[1], 46);

    // T5: reset during ACC of neuron 1.
    preload(1000, 2000);
    start_ts(1'b0, 4'b1111);
    for (int c = 1; c <= 12; c++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mark();
    @(negedge clk);
    chk("t5_strobes", 32'({bus.busy, bus.done, bus.w_rd_en, bus.vmem_rd_en, bus.vmem_wr_en,
                           bus.neu_load_en, bus.neu_input_valid, bus.neu_output_en}), 32'd0);
    repeat (20) @(negedge clk);
    chk("t5_no_wr", wr_addr_q.size() - m_wr, 0);
    chk("t5_vmem0", vmem[0], 1010);
    chk("t5_vmem1", vmem[1], 2000);
    @(posedge clk);
    #1;
    start_ts(1'b0, 4'b1111);
    wait_done("t5b", cyc);
    chk("t5b_vmem0", vmem[0], 1020);
    chk("t5b_vmem1", vmem[1], 2026);

    // T6: random timesteps against a reference sum.
    preload(3, 4);
    ref_v[0] = 3;
    ref_v[1] = 4;
    for (int t = 0; t < 50; t++) begin
      for (int k = 0; k < N_IN*N_OUT; k++) wmem[k] = int'($urandom_range(0, 1000));
      fs  = 1'($urandom_range(0, 1));
      spk = N_IN'($urandom);
      for (int j = 0; j < N_OUT; j++) begin
        sum = fs ? 0 : ref_v[j];
        for (int i = 0; i < N_IN; i++) if (spk[i]) sum += wmem[j*N_IN + i];
        ref_v[j] = sum;
      end
      start_ts(fs, spk);
      wait_done($sformatf("r%0d", t), cyc);
      chk($sformatf("r%0d_vmem0", t), vmem[0], ref_v[0]);
      chk($sformatf("r%0d_vmem1", t), vmem[1], ref_v[1]);
    end

    chk("strobe_exclusive", excl_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inf_layer_seq.md
Name: inf_layer_seq

Overview:
- Sequencer for one time-multiplexed acc_INF_neuron datapath evaluating a fully connected integrate-no-fire layer of N_OUT neurons over N_IN input spikes per timestep.
- Per output neuron:
  - reads the neuron's stored membrane voltage from vmem and loads it into the accumulator;
  - streams the weight row from weight memory with spike-gated input_valid;
  - latches the result with output_en;
  - writes the result back to vmem.
- Sits between the timestep controller (start/done) and the neuron, weight ROM and membrane RAM.

Parameters:
- N_IN, 16, inputs per output neuron (>=2)
- N_OUT, 10, output neurons in the layer (>=1)
- W_AW, $clog2(N_IN*N_OUT), weight memory address width
- V_AW, $clog2(N_OUT) (min 1), membrane memory address width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin one timestep; sampled only in IDLE
- first_step  in  1  sampled with start; 1 = skip vmem load (accumulator starts from 0)
- spike_in  in  N_IN  input spikes, captured on accepted start
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  one-cycle pulse in DONE
- w_rd_en  out  1  weight memory read strobe (data valid next cycle)
- w_addr  out  W_AW  weight address = j*N_IN + i
- vmem_rd_en  out  1  membrane RAM read strobe (data valid next cycle, wired to neuron input_mem_vol)
- vmem_rd_addr  out  V_AW  = j
- vmem_wr_en  out  1  membrane RAM write strobe (data = neuron output_mem_vol, wired externally)
- vmem_wr_addr  out  V_AW  = j
- neu_load_en  out  1  to neuron load_en
- neu_input_valid  out  1  to neuron input_valid
- neu_output_en  out  1  to neuron output_en
- cur_neuron  out  V_AW  current output index j (debug / result capture)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs, counters and the spike register clear to 0. Reset mid-timestep aborts with no further strobes. The neuron is reset by the same rst_n.
- Accepted start: start=1 in IDLE. Latches spike_in into spk_q and first_step into fs_q, clears j=0, goes to RD. start in any other state is ignored.
- Outputs are Moore: registered or decoded from state and counters only.
- States, with one cycle each unless noted:
  - IDLE: all strobes 0.
  - RD: vmem_rd_en = !fs_q; vmem_rd_addr = j.
  - LD: neu_load_en = !fs_q. Clears i=0.
  - ACC (N_IN cycles, i = 0..N_IN-1): w_rd_en=1, w_addr=j*N_IN+i. A one-stage pipeline register sets neu_input_valid in the next cycle to spk_q[i]. Leaves ACC when i==N_IN-1.
  - DRN: carries neu_input_valid for i=N_IN-1; no read.
  - OUT: neu_output_en=1. The neuron latches output_mem_vol and zeroes its accumulator at this edge.
  - WB: vmem_wr_en=1, vmem_wr_addr=j. If j==N_OUT-1, go to DONE; else j<=j+1 and go to RD.
  - DONE: done=1, then IDLE.
- Exclusivity guarantees:
  - neu_load_en, neu_input_valid and neu_output_en are never high in the same cycle. This is required because the neuron prioritises output_en over load_en over input_valid.
  - vmem_rd_en and vmem_wr_en are never both high.
- Latency: per neuron N_IN+5 cycles. A timestep takes N_OUT*(N_IN+5) busy cycles plus the DONE cycle. Back-to-back: the earliest next start is accepted in the IDLE cycle after DONE.
- first_step=1: the timing is identical and only the load strobes are suppressed. The accumulator is 0 after reset or after the previous OUT.
- spike_in changes during busy have no effect; spk_q is used.
- Address arithmetic is unsigned. j*N_IN+i never exceeds N_IN*N_OUT-1, so no wrap occurs.

Decomposition:
- Shared package inf_pkg:
  - state enum (IDLE, RD, LD, ACC, DRN, OUT, WB, DONE);
  - localparam CYC_PER_NEURON = N_IN+5;
  - clog2-based width helpers.
- No sub-module. The index counters and the single valid pipeline register stay inline. The bench instantiates acc_INF_neuron plus behavioural memories around it.

Test Plan:
- N_IN=4, N_OUT=2; reset, start with spike_in=4'b1111, first_step=1 -> busy for 18 cycles; done pulses once on cycle 19 after the start cycle; w_addr sequence 0..3 then 4..7; vmem_rd_en never high; vmem_wr_en high twice, at addr 0 then 1.
- Weights row0={1,2,3,4}, vmem[0]=100, first_step=0, spike_in=4'b0101 -> neu_input_valid high only for i=0 and i=2; vmem[0] written 104 (100+1+3).
- spike_in=0, vmem={7,9} -> no neu_input_valid pulses; vmem rewritten {7,9}; neu_load_en pulses exactly N_OUT times.
- start held high throughout and spike_in toggled mid-run -> a second timestep begins only after the IDLE cycle following DONE; results use the spikes captured at start.
- rst_n=0 for one cycle during ACC of neuron 1 -> next cycle all strobes 0, busy=0, no vmem_wr_en for neuron 1; a new start then completes normally.
- Random spikes and weights over 50 timesteps -> vmem matches the reference model every timestep; assertion that the strobes are one-hot-or-zero holds in every cycle.
